bitwise_sweep_checker: RTL and testbench

Synthesizable self-checking stimulus engine for the 4-bit bitwise/logical operator block. On `start` it drives every one of the 256 (a, b) operand pairs into the operator block and waits a programmable settle time. It then samples the eight operator results, compares them against an internal golden model, and reports pass/fail, the error count and the first failing vector. It sits on the driving side of the operator block's `a`/`b` inputs and the observing side of its `rslt_*` outputs.

---
 rtl/bitwise_sweep_checker.sv | 158 +++++++++++++++
 tb/tb_bitwise_sweep_checker.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : bitwise_sweep_checker
// Brief    : Sweeps all 256 4-bit operand pairs through the operator block and
//            checks the eight results against a built-in golden model.
// Revision : 1.0
// ============================================================================
module bitwise_sweep_checker #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] a_o,
    output logic [3:0] b_o,
    input  logic [3:0] bw_and,
    input  logic [3:0] bw_or,
    input  logic [3:0] bw_not,
    input  logic [3:0] bw_xor,
    input  logic [3:0] bw_xnor,
    input  logic       log_and,
    input  logic       log_or,
    input  logic       log_not,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [8:0] err_count,
    output logic       first_fail_valid,
    output logic [3:0] first_fail_a,
    output logic [3:0] first_fail_b,
    output logic [7:0] first_fail_mask
);

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_DRIVE = 2'd1;
    localparam logic [1:0] C_CHECK = 2'd2;
    localparam logic [1:0] C_DONE  = 2'd3;

    localparam logic [3:0] C_SETTLE_LAST = 4'(SETTLE - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [3:0] settle_q, settle_d;
    logic [8:0] err_count_q, err_count_d;
    logic       ff_valid_q, ff_valid_d;
    logic [3:0] ff_a_q, ff_a_d;
    logic [3:0] ff_b_q, ff_b_d;
    logic [7:0] ff_mask_q, ff_mask_d;

    logic [3:0] w_a;
    logic [3:0] w_b;
    logic [7:0] w_mask;

    assign w_a = idx_q[7:4];
    assign w_b = idx_q[3:0];

    // Each mask bit flags a whole-result mismatch against the golden value.
    always_comb begin
        w_mask    = 8'd0;
        w_mask[0] = (bw_and  != (w_a & w_b));
        w_mask[1] = (bw_or   != (w_a | w_b));
        w_mask[2] = (bw_not  != (~w_a));
        w_mask[3] = (bw_xor  != (w_a ^ w_b));
        w_mask[4] = (bw_xnor != (~(w_a ^ w_b)));
        w_mask[5] = (log_and != ((w_a != 4'd0) && (w_b != 4'd0)));
        w_mask[6] = (log_or  != ((w_a != 4'd0) || (w_b != 4'd0)));
        w_mask[7] = (log_not != (w_a == 4'd0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= C_IDLE;
            idx_q       <= 8'd0;
            settle_q    <= 4'd0;
            err_count_q <= 9'd0;
            ff_valid_q  <= 1'b0;
            ff_a_q      <= 4'd0;
            ff_b_q      <= 4'd0;
            ff_mask_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            settle_q    <= settle_d;
            err_count_q <= err_count_d;
            ff_valid_q  <= ff_valid_d;
            ff_a_q      <= ff_a_d;
            ff_b_q      <= ff_b_d;
            ff_mask_q   <= ff_mask_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        settle_d    = settle_q;
        err_count_d = err_count_q;
        ff_valid_d  = ff_valid_q;
        ff_a_d      = ff_a_q;
        ff_b_d      = ff_b_q;
        ff_mask_d   = ff_mask_q;
        case (state_q)
            C_IDLE, C_DONE: begin
                if (start) begin
                    state_d     = C_DRIVE;
                    idx_d       = 8'd0;
                    settle_d    = 4'd0;
                    err_count_d = 9'd0;
                    ff_valid_d  = 1'b0;
                    ff_a_d      = 4'd0;
                    ff_b_d      = 4'd0;
                    ff_mask_d   = 8'd0;
                end
            end
            C_DRIVE: begin
                if (settle_q == C_SETTLE_LAST) begin
                    state_d = C_CHECK;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            C_CHECK: begin
                if (w_mask != 8'd0) begin
                    err_count_d = err_count_q + 9'd1;
                    // Only the earliest failing vector is kept.
                    if (!ff_valid_q) begin
                        ff_valid_d = 1'b1;
                        ff_a_d     = w_a;
                        ff_b_d     = w_b;
                        ff_mask_d  = w_mask;
                    end
                end
                if (idx_q == 8'hFF) begin
                    state_d = C_DONE;
                end else begin
                    idx_d    = idx_q + 8'd1;
                    settle_d = 4'd0;
                    state_d  = C_DRIVE;
                end
            end
            default: state_d = C_IDLE;
        endcase
    end

    always_comb begin
        a_o              = w_a;
        b_o              = w_b;
        busy             = (state_q == C_DRIVE) || (state_q == C_CHECK);
        done             = (state_q == C_DONE);
        pass             = (state_q == C_DONE) && (err_count_q == 9'd0);
        err_count        = err_count_q;
        first_fail_valid = ff_valid_q;
        first_fail_a     = ff_a_q;
        first_fail_b     = ff_b_q;
        first_fail_mask  = ff_mask_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_bitwise_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitwise_sweep_checker
// Brief    : Bench for bitwise_sweep_checker with a fault-injectable operator
//            block and a sweep-level model of the expected outputs.
// Revision : 1.0
// ============================================================================
module tb_bitwise_sweep_checker;

    typedef struct packed {
        logic [3:0] an, orr, nt, xr, xn;
        logic       la, lo, ln;
    } ops_t;

    typedef struct packed {
        logic       busy, done, pass;
        logic [8:0] err;
        logic       ffv;
        logic [3:0] ffa, ffb;
        logic [7:0] ffm;
        logic [3:0] a, b;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] fault = 2'd0;
    logic [1:0] start_v = 2'b00;
    logic       checking = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Instance 0: SETTLE = 1, instance 1: SETTLE = 3
    logic [3:0] a0, b0, a1, b1;
    logic       busy0, done0, pass0, ffv0, busy1, done1, pass1, ffv1;
    logic [8:0] err0, err1;
    logic [3:0] ffa0, ffb0, ffa1, ffb1;
    logic [7:0] ffm0, ffm1;
    ops_t       ops0, ops1;
    obs_t       obs0, obs1;

    function automatic ops_t golden(input logic [3:0] a, input logic [3:0] b);
        ops_t g;
        g.an  = a & b;
        g.orr = a | b;
        g.nt  = ~a;
        g.xr  = a ^ b;
        g.xn  = ~(a ^ b);
        g.la  = (a != 4'd0) && (b != 4'd0);
        g.lo  = (a != 4'd0) || (b != 4'd0);
        g.ln  = (a == 4'd0);
        return g;
    endfunction

    // Operator block with a selectable planted fault.
    function automatic ops_t op_block(input logic [3:0] a, input logic [3:0] b, input logic [1:0] f);
        ops_t o;
        o = golden(a, b);
        case (f)
            2'd1:    o.ln    = 1'b0;
            2'd2:    o.an[0] = 1'b1;
            2'd3:    o.xn    = o.xr;
            default: ;
        endcase
        return o;
    endfunction

    always_comb ops0 = op_block(a0, b0, fault);
    always_comb ops1 = op_block(a1, b1, fault);

    bitwise_sweep_checker #(.SETTLE(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a_o(a0), .b_o(b0),
        .bw_and(ops0.an), .bw_or(ops0.orr), .bw_not(ops0.nt), .bw_xor(ops0.xr), .bw_xnor(ops0.xn),
        .log_and(ops0.la), .log_or(ops0.lo), .log_not(ops0.ln),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_valid(ffv0), .first_fail_a(ffa0), .first_fail_b(ffb0), .first_fail_mask(ffm0)
    );

    bitwise_sweep_checker #(.SETTLE(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a_o(a1), .b_o(b1),
        .bw_and(ops1.an), .bw_or(ops1.orr), .bw_not(ops1.nt), .bw_xor(ops1.xr), .bw_xnor(ops1.xn),
        .log_and(ops1.la), .log_or(ops1.lo), .log_not(ops1.ln),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_valid(ffv1), .first_fail_a(ffa1), .first_fail_b(ffb1), .first_fail_mask(ffm1)
    );

    assign obs0 = {busy0, done0, pass0, err0, ffv0, ffa0, ffb0, ffm0, a0, b0};
    assign obs1 = {busy1, done1, pass1, err1, ffv1, ffa1, ffb1, ffm1, a1, b1};

    // Sweep-level expectations for the current fault: per-vector masks,
    // prefix failure counts and the first failing index (256 = none).
    logic [7:0] exp_mask [256];
    int         pc [257];
    int         first_idx;

    task automatic prepare();
        ops_t g, o;
        logic [7:0] m;
        logic [7:0] v;
        pc[0]     = 0;
        first_idx = 256;
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            g = golden(v[7:4], v[3:0]);
            o = op_block(v[7:4], v[3:0], fault);
            m = {o.ln != g.ln, o.lo != g.lo, o.la != g.la, o.xn != g.xn,
                 o.xr != g.xr, o.nt != g.nt, o.orr != g.orr, o.an != g.an};
            exp_mask[i] = m;
            pc[i+1]     = pc[i] + ((m != 8'd0) ? 1 : 0);
            if (m != 8'd0 && first_idx == 256) first_idx = i;
        end
    endtask

    // Model time: edges elapsed since the accepted start edge.
    logic [1:0] m_act = 2'b00;
    int         m_t [2];

    function automatic int settle_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_act[k] <= 1'b0;
                m_t[k]   <= 0;
            end else if (m_act[k] && m_t[k] < 256 * (settle_of(k) + 1)) begin
                m_t[k] <= m_t[k] + 1;
            end else if (start_v[k]) begin
                m_act[k] <= 1'b1;
                m_t[k]   <= 0;
            end
        end
    end

    function automatic obs_t exp_obs(input int k);
        obs_t e;
        int   s, n, comp, idx;
        s    = settle_of(k);
        n    = 256 * (s + 1);
        comp = m_act[k] ? (m_t[k] / (s + 1)) : 0;
        idx  = !m_act[k] ? 0 : ((comp < 256) ? comp : 255);
        e.busy = m_act[k] && (m_t[k] < n);
        e.done = m_act[k] && (m_t[k] >= n);
        e.err  = 9'(pc[comp]);
        e.pass = e.done && (pc[comp] == 0);
        e.ffv  = (first_idx < comp);
        e.ffa  = e.ffv ? 4'(first_idx >> 4) : 4'd0;
        e.ffb  = e.ffv ? 4'(first_idx & 15) : 4'd0;
        e.ffm  = e.ffv ? exp_mask[first_idx] : 8'd0;
        e.a    = 4'(idx >> 4);
        e.b    = 4'(idx & 15);
        return e;
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < 2; k++) begin
                obs_t e, g;
                e = exp_obs(k);
                g = (k == 0) ? obs0 : obs1;
                n_cmp++;
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL cycle_check dut%0d t=%0t got=%h want=%h", k, $time, g, e);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic busy_of(input int k);
        return (k == 0) ? busy0 : busy1;
    endfunction

    task automatic run(input int k, input logic [1:0] f, input bit do_rst,
                       input int restart_at, output int cycles);
        if (do_rst) begin
            fault = f;
            prepare();
            rst = 1'b1;
            step();
            rst = 1'b0;
        end
        start_v[k] = 1'b1;
        step();
        start_v[k] = 1'b0;
        cycles = 0;
        while (busy_of(k) && cycles < 5000) begin
            start_v[k] = (cycles == restart_at);
            cycles++;
            step();
        end
        start_v[k] = 1'b0;
        if (cycles >= 5000) check("sweep_timeout", cycles, -1);
    endtask

    int cyc;

    initial begin
        prepare();
        #1 rst = 1'b1;
        checking = 1'b1;
        step();
        step();
        check("reset_busy", busy0, 0);
        check("reset_done", done0, 0);
        check("reset_pass", pass0, 0);
        check("reset_err", err0, 0);
        check("reset_ffv", ffv0, 0);
        check("reset_ab", {a0, b0}, 0);
        rst = 1'b0;
        step();

        run(0, 2'd0, 1'b1, -1, cyc);
        check("good_busy_cycles", cyc, 512);
        check("good_done", done0, 1);
        check("good_pass", pass0, 1);
        check("good_err", err0, 0);
        check("good_ffv", ffv0, 0);
        check("good_last_ab", {a0, b0}, 8'hFF);

        run(0, 2'd1, 1'b1, -1, cyc);
        check("lnot_err", err0, 16);
        check("lnot_first_ab", {ffa0, ffb0}, 8'h00);
        check("lnot_mask", ffm0, 8'h80);
        check("lnot_ffv", ffv0, 1);
        check("lnot_pass", pass0, 0);

        run(0, 2'd2, 1'b1, -1, cyc);
        check("and0_err", err0, 192);
        check("and0_first_ab", {ffa0, ffb0}, 8'h00);
        check("and0_mask", ffm0, 8'h01);

        run(0, 2'd3, 1'b1, -1, cyc);
        check("xnor_err", err0, 256);
        check("xnor_first_ab", {ffa0, ffb0}, 8'h00);
        check("xnor_mask", ffm0, 8'h10);
        check("xnor_pass", pass0, 0);

        run(1, 2'd0, 1'b1, 100, cyc);
        check("settle3_cycles", cyc, 1024);
        check("settle3_done", done1, 1);
        check("settle3_pass", pass1, 1);

        fault = 2'd2;
        prepare();
        rst = 1'b1;
        step();
        rst = 1'b0;
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        repeat (80) step();
        check("mid_busy_before_rst", busy0, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy0, 0);
        check("abort_done", done0, 0);
        check("abort_err", err0, 0);
        check("abort_ff", {ffv0, ffa0, ffb0, ffm0}, 0);
        check("abort_ab", {a0, b0}, 0);
        fault = 2'd0;
        prepare();
        step();
        rst = 1'b0;
        step();
        run(0, 2'd0, 1'b0, -1, cyc);
        check("rerun_cycles", cyc, 512);
        check("rerun_pass", pass0, 1);
        check("rerun_err", err0, 0);

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
